// File: rtl/gcm_pkg.sv
// Shared definitions for the AES-GCM sequencer: block width, FSM states,
// counter constants and the length-block helper.
package gcm_pkg;

    localparam int unsigned BLK_W     = 128;
    localparam int unsigned IV_W      = 96;
    // Each half of the length block is a 64-bit bit count; the block count
    // sits above a fixed 7-bit shift (x128 bits per block).
    localparam int unsigned LEN_CNT_W = 57;
    localparam logic [31:0] J0_LOW    = 32'h00000001;

    typedef enum logic [3:0] {
        StIdle,
        StHGen,
        StJ0Enc,
        StAadIn,
        StAadMul,
        StCtrEnc,
        StPtIn,
        StCtOut,
        StCtMul,
        StLenMul,
        StTag
    } gcm_state_e;

    // Increment the low 32 bits modulo 2^32; the upper 96 bits never change.
    function automatic logic [BLK_W-1:0] inc32(input logic [BLK_W-1:0] blk);
        return {blk[BLK_W-1:32], blk[31:0] + 32'd1};
    endfunction

    // Length block: bit length of AAD in the upper half, of text in the lower.
    function automatic logic [BLK_W-1:0] len_block(input logic [LEN_CNT_W-1:0] aad_cnt,
                                                   input logic [LEN_CNT_W-1:0] pt_cnt);
        return {aad_cnt, 7'b0, pt_cnt, 7'b0};
    endfunction

endpackage

// File: rtl/gcm_ctr32.sv
// GCM counter register: loads J0 from the nonce and steps with inc32.
module gcm_ctr32
    import gcm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [IV_W-1:0]  iv,
    input  logic             step,
    output logic [BLK_W-1:0] ctr
);

    logic [BLK_W-1:0] ctr_q, ctr_d;

    // Next counter value: load wins over step.
    always_comb begin
        ctr_d = ctr_q;
        if (load) begin
            ctr_d = {iv, J0_LOW};
        end else if (step) begin
            ctr_d = inc32(ctr_q);
        end
    end

    // Counter register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr = ctr_q;

endmodule

// File: rtl/gcm_seq_ctrl.sv
// AES-GCM encryption sequencer. Owns the counter and GHASH accumulator and
// schedules the external AES core and GF(2^128) multiplier, one op at a time.
module gcm_seq_ctrl
    import gcm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IV_W-1:0]  iv,
    input  logic [CNT_W-1:0] aad_blocks,
    input  logic [CNT_W-1:0] pt_blocks,
    input  logic [BLK_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [BLK_W-1:0] ct,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic             aes_start,
    output logic [BLK_W-1:0] aes_in,
    input  logic             aes_done,
    input  logic [BLK_W-1:0] aes_out,
    output logic             mul_start,
    output logic [BLK_W-1:0] mul_a,
    output logic [BLK_W-1:0] mul_b,
    input  logic             mul_done,
    input  logic [BLK_W-1:0] mul_p,
    output logic [BLK_W-1:0] tag,
    output logic             busy,
    output logic             finished
);

    gcm_state_e       state_q, state_d;
    logic [CNT_W-1:0] aad_len_q, aad_len_d;
    logic [CNT_W-1:0] pt_len_q, pt_len_d;
    logic [CNT_W-1:0] aad_rem_q, aad_rem_d;
    logic [CNT_W-1:0] pt_rem_q, pt_rem_d;
    logic [BLK_W-1:0] y_q, y_d;
    logic [BLK_W-1:0] h_q, h_d;
    logic [BLK_W-1:0] ekj0_q, ekj0_d;
    logic [BLK_W-1:0] ks_q, ks_d;
    logic             ks_valid_q, ks_valid_d;
    logic [BLK_W-1:0] ct_q, ct_d;
    logic             ct_valid_q, ct_valid_d;
    logic [BLK_W-1:0] tag_q, tag_d;
    logic [BLK_W-1:0] aes_in_q, aes_in_d;
    logic             aes_start_q, aes_start_d;
    logic [BLK_W-1:0] mul_a_q, mul_a_d;
    logic             mul_start_q, mul_start_d;
    logic             finished_q, finished_d;
    logic             ctr_load, ctr_step;
    logic [BLK_W-1:0] ctr;
    logic [BLK_W-1:0] len_blk;

    gcm_ctr32 u_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (ctr_load),
        .iv    (iv),
        .step  (ctr_step),
        .ctr   (ctr)
    );

    assign len_blk = len_block(LEN_CNT_W'(aad_len_q), LEN_CNT_W'(pt_len_q));

    // Next-state, datapath updates and operation issue for every state.
    always_comb begin
        state_d     = state_q;
        aad_len_d   = aad_len_q;
        pt_len_d    = pt_len_q;
        aad_rem_d   = aad_rem_q;
        pt_rem_d    = pt_rem_q;
        y_d         = y_q;
        h_d         = h_q;
        ekj0_d      = ekj0_q;
        ks_d        = ks_q;
        ks_valid_d  = ks_valid_q;
        ct_d        = ct_q;
        ct_valid_d  = ct_valid_q;
        tag_d       = tag_q;
        aes_in_d    = aes_in_q;
        aes_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_start_d = 1'b0;
        finished_d  = 1'b0;
        ctr_load    = 1'b0;
        ctr_step    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    aad_len_d   = aad_blocks;
                    pt_len_d    = pt_blocks;
                    aad_rem_d   = aad_blocks;
                    pt_rem_d    = pt_blocks;
                    y_d         = '0;
                    ks_valid_d  = 1'b0;
                    ctr_load    = 1'b1;
                    // Hash subkey H = E(K, 0^128).
                    aes_in_d    = '0;
                    aes_start_d = 1'b1;
                    state_d     = StHGen;
                end
            end
            StHGen: begin
                if (aes_done) begin
                    h_d         = aes_out;
                    aes_in_d    = ctr;  // still J0 here
                    aes_start_d = 1'b1;
                    state_d     = StJ0Enc;
                end
            end
            StJ0Enc: begin
                if (aes_done) begin
                    ekj0_d = aes_out;
                    if (aad_len_q != '0) begin
                        state_d = StAadIn;
                    end else if (pt_len_q != '0) begin
                        state_d = StCtrEnc;
                    end else begin
                        mul_a_d     = y_q ^ len_blk;
                        mul_start_d = 1'b1;
                        state_d     = StLenMul;
                    end
                end
            end
            StAadIn: begin
                if (din_valid) begin
                    mul_a_d     = y_q ^ din;
                    mul_start_d = 1'b1;
                    state_d     = StAadMul;
                end
            end
            StAadMul: begin
                if (mul_done) begin
                    y_d       = mul_p;
                    aad_rem_d = aad_rem_q - CNT_W'(1);
                    if (aad_rem_q != CNT_W'(1)) begin
                        state_d = StAadIn;
                    end else if (pt_len_q != '0) begin
                        state_d = StCtrEnc;
                    end else begin
                        mul_a_d     = mul_p ^ len_blk;
                        mul_start_d = 1'b1;
                        state_d     = StLenMul;
                    end
                end
            end
            StCtrEnc: begin
                ctr_step    = 1'b1;
                aes_in_d    = inc32(ctr);
                aes_start_d = 1'b1;
                state_d     = StPtIn;
            end
            StPtIn: begin
                // Keystream first; only then is a plaintext block accepted.
                if (!ks_valid_q) begin
                    if (aes_done) begin
                        ks_d       = aes_out;
                        ks_valid_d = 1'b1;
                    end
                end else if (din_valid) begin
                    ct_d       = din ^ ks_q;
                    ct_valid_d = 1'b1;
                    ks_valid_d = 1'b0;
                    pt_rem_d   = pt_rem_q - CNT_W'(1);
                    state_d    = StCtOut;
                end
            end
            StCtOut: begin
                if (ct_ready) begin
                    ct_valid_d  = 1'b0;
                    mul_a_d     = y_q ^ ct_q;
                    mul_start_d = 1'b1;
                    state_d     = StCtMul;
                end
            end
            StCtMul: begin
                if (mul_done) begin
                    y_d = mul_p;
                    if (pt_rem_q != '0) begin
                        state_d = StCtrEnc;
                    end else begin
                        mul_a_d     = mul_p ^ len_blk;
                        mul_start_d = 1'b1;
                        state_d     = StLenMul;
                    end
                end
            end
            StLenMul: begin
                if (mul_done) begin
                    y_d        = mul_p;
                    tag_d      = mul_p ^ ekj0_q;
                    finished_d = 1'b1;
                    state_d    = StTag;
                end
            end
            StTag: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered output pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            aad_len_q   <= '0;
            pt_len_q    <= '0;
            aad_rem_q   <= '0;
            pt_rem_q    <= '0;
            y_q         <= '0;
            h_q         <= '0;
            ekj0_q      <= '0;
            ks_q        <= '0;
            ks_valid_q  <= 1'b0;
            ct_q        <= '0;
            ct_valid_q  <= 1'b0;
            tag_q       <= '0;
            aes_in_q    <= '0;
            aes_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_start_q <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            aad_len_q   <= aad_len_d;
            pt_len_q    <= pt_len_d;
            aad_rem_q   <= aad_rem_d;
            pt_rem_q    <= pt_rem_d;
            y_q         <= y_d;
            h_q         <= h_d;
            ekj0_q      <= ekj0_d;
            ks_q        <= ks_d;
            ks_valid_q  <= ks_valid_d;
            ct_q        <= ct_d;
            ct_valid_q  <= ct_valid_d;
            tag_q       <= tag_d;
            aes_in_q    <= aes_in_d;
            aes_start_q <= aes_start_d;
            mul_a_q     <= mul_a_d;
            mul_start_q <= mul_start_d;
            finished_q  <= finished_d;
        end
    end

    // Gated by reset so a valid beat coinciding with reset never handshakes.
    assign din_ready = reset && ((state_q == StAadIn) || ((state_q == StPtIn) && ks_valid_q));
    assign ct        = ct_q;
    assign ct_valid  = ct_valid_q;
    assign aes_start = aes_start_q;
    assign aes_in    = aes_in_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = h_q;
    assign tag       = tag_q;
    assign busy      = (state_q != StIdle);
    assign finished  = finished_q;

endmodule

// File: tb/tb_gcm_seq_ctrl.sv
// Self-checking bench for gcm_seq_ctrl: AES and multiplier responders with
// random latency, and a block-level GCM reference model.
module tb_gcm_seq_ctrl;

    logic         clk;
    logic         reset;
    logic         start;
    logic [95:0]  iv;
    logic [15:0]  aad_blocks;
    logic [15:0]  pt_blocks;
    logic [127:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] ct;
    logic         ct_valid;
    logic         ct_ready;
    logic         aes_start;
    logic [127:0] aes_in;
    logic         aes_done;
    logic [127:0] aes_out;
    logic         mul_start;
    logic [127:0] mul_a;
    logic [127:0] mul_b;
    logic         mul_done;
    logic [127:0] mul_p;
    logic [127:0] tag;
    logic         busy;
    logic         finished;

    int n_checks = 0;
    int n_bad    = 0;

    logic [127:0] aes_log[$];
    logic [127:0] mul_log[$];
    bit           aes_pend;
    int           aes_wait;
    logic [127:0] aes_cap;
    bit           mul_pend;
    int           mul_wait;
    logic [127:0] mul_cap_a;
    logic [127:0] mul_cap_b;

    logic [127:0] r_tag, r_ct0, r_h;
    int           r_na, r_np;

    gcm_seq_ctrl #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .iv         (iv),
        .aad_blocks (aad_blocks),
        .pt_blocks  (pt_blocks),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ct         (ct),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .aes_start  (aes_start),
        .aes_in     (aes_in),
        .aes_done   (aes_done),
        .aes_out    (aes_out),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_p      (mul_p),
        .tag        (tag),
        .busy       (busy),
        .finished   (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Zero-key AES for the three inputs the known vectors need; a fixed
    // scrambler stands in for the cipher elsewhere.
    function automatic logic [127:0] aes_model(input logic [127:0] x);
        case (x)
            128'h0:         return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
            {96'h0, 32'h1}: return 128'h58e2fccefa7e3061367f1d57a4e7455a;
            {96'h0, 32'h2}: return 128'h0388dace60b6a392f328c2b971b2fe78;
            default:        return {x[60:0], x[127:61]} ^ (x * 128'h9e3779b97f4a7c15)
                                   ^ 128'h5a5a_1234_a5a5_8765_0f0f_f0f0_3c3c_c3c3;
        endcase
    endfunction

    // GF(2^128) multiply in GCM bit order (bit 0 is the MSB).
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    // AES core stand-in: one request at a time, 1..4 cycle latency.
    initial begin
        aes_done = 1'b0;
        aes_out  = '0;
        aes_pend = 1'b0;
        forever begin
            @(negedge clk);
            aes_done = 1'b0;
            if (!reset) begin
                aes_pend = 1'b0;
            end else if (aes_pend) begin
                check_eq("aes_one_shot", 128'(aes_start), 128'd0);
                check_eq("aes_in_hold", aes_in, aes_cap);
                if (aes_wait == 0) begin
                    aes_done = 1'b1;
                    aes_out  = aes_model(aes_cap);
                    aes_pend = 1'b0;
                end else begin
                    aes_wait--;
                end
            end else if (aes_start) begin
                aes_pend = 1'b1;
                aes_cap  = aes_in;
                aes_wait = $urandom_range(0, 3);
                aes_log.push_back(aes_in);
            end
        end
    end

    // Multiplier stand-in: one request at a time, 1..4 cycle latency.
    initial begin
        mul_done = 1'b0;
        mul_p    = '0;
        mul_pend = 1'b0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (!reset) begin
                mul_pend = 1'b0;
            end else if (mul_pend) begin
                check_eq("mul_one_shot", 128'(mul_start), 128'd0);
                check_eq("mul_a_hold", mul_a, mul_cap_a);
                check_eq("mul_b_hold", mul_b, mul_cap_b);
                if (mul_wait == 0) begin
                    mul_done = 1'b1;
                    mul_p    = gf_mul(mul_cap_a, mul_cap_b);
                    mul_pend = 1'b0;
                end else begin
                    mul_wait--;
                end
            end else if (mul_start) begin
                mul_pend  = 1'b1;
                mul_cap_a = mul_a;
                mul_cap_b = mul_b;
                mul_wait  = $urandom_range(0, 3);
                mul_log.push_back(mul_a);
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_ctl"}, 128'({din_ready, ct_valid, aes_start, mul_start, busy, finished}),
                 128'd0);
        check_eq({name, "_ct"}, ct, 128'd0);
        check_eq({name, "_tag"}, tag, 128'd0);
        check_eq({name, "_aes_in"}, aes_in, 128'd0);
        check_eq({name, "_mul_a"}, mul_a, 128'd0);
        check_eq({name, "_mul_b"}, mul_b, 128'd0);
    endtask

    // One encryption. mode 0: random ready, 1: hold off the first ct for 10
    // cycles, 2: reset right after the first ct handshake, 3: extra start
    // while the first AAD block is being multiplied. Called and returns at negedge.
    task automatic run_gcm(input logic [95:0] v_iv, input int na, input int np,
                           input bit zero_data, input int mode,
                           output logic [127:0] o_tag, output logic [127:0] o_ct0,
                           output logic [127:0] o_h);
        logic [127:0] data[$];
        logic [127:0] ct_exp[$];
        logic [127:0] exp_aes[$];
        logic [127:0] h, j0, y, blk, cb, c, lblk, last_a, exp_tag, held_ct;
        int  di, ci, fin, cyc, hold, post;
        bit  saw_rdy, inj, abort_req, done;

        // Reference model, block by block.
        h = aes_model('0);
        j0 = {v_iv, 32'h1};
        y = '0;
        exp_aes.push_back('0);
        exp_aes.push_back(j0);
        for (int i = 0; i < na; i++) begin
            blk = zero_data ? '0 : {$urandom, $urandom, $urandom, $urandom};
            data.push_back(blk);
            y = gf_mul(y ^ blk, h);
        end
        for (int i = 0; i < np; i++) begin
            blk = zero_data ? '0 : {$urandom, $urandom, $urandom, $urandom};
            data.push_back(blk);
            cb = {v_iv, 32'(i + 2)};
            exp_aes.push_back(cb);
            c = blk ^ aes_model(cb);
            ct_exp.push_back(c);
            y = gf_mul(y ^ c, h);
        end
        lblk = {64'(na) * 64'd128, 64'(np) * 64'd128};
        last_a = y ^ lblk;
        exp_tag = gf_mul(last_a, h) ^ aes_model(j0);

        aes_log.delete();
        mul_log.delete();
        o_ct0 = '0;
        di = 0; ci = 0; fin = 0; cyc = 0; hold = 0; post = 0;
        saw_rdy = 0; inj = 0; abort_req = 0; done = 0;
        held_ct = '0;

        iv = v_iv;
        aad_blocks = 16'(na);
        pt_blocks = 16'(np);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        iv = ~v_iv;
        aad_blocks = 16'hffff;
        pt_blocks = 16'hffff;

        while (!done) begin
            if (abort_req) begin
                reset = 1'b0;
                din_valid = 1'b1;
                ct_ready = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check_reset_outputs("abort");
                end
                reset = 1'b1;
                din_valid = 1'b0;
                o_tag = tag;
                o_h = mul_b;
                return;
            end
            if (inj) begin
                start = 1'b1;
                iv = ~v_iv;
                aad_blocks = 16'd7;
                pt_blocks = 16'd7;
                inj = 0;
            end else begin
                start = 1'b0;
            end
            if (din_ready) saw_rdy = 1;
            if (finished) begin
                fin++;
                check_eq("tag", tag, exp_tag);
            end
            if (fin > 0) post++;

            if (di < data.size()) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din = data[di];
            end else begin
                din_valid = 1'b0;
            end
            if (din_valid && din_ready) begin
                di++;
                if (mode == 3 && di == 1 && na > 0) inj = 1;
            end

            if (mode == 1 && ci == 0 && (ct_valid || hold > 0) && hold < 10) begin
                ct_ready = 1'b0;
                if (hold == 0) begin
                    held_ct = ct;
                end else begin
                    check_eq("bp_ct", ct, held_ct);
                    check_eq("bp_vld", 128'(ct_valid), 128'd1);
                    check_eq("bp_no_mul", 128'(mul_start), 128'd0);
                end
                hold++;
            end else begin
                ct_ready = ($urandom_range(0, 2) != 0);
            end
            if (ct_valid && ct_ready) begin
                if (ci < ct_exp.size()) check_eq($sformatf("ct%0d", ci), ct, ct_exp[ci]);
                if (ci == 0) o_ct0 = ct;
                if (mode == 2) abort_req = 1;
                ci++;
            end

            cyc++;
            if (post > 3) begin
                done = 1;
            end else if (cyc > 3000) begin
                check_eq("timeout_fin", 128'(fin), 128'd1);
                done = 1;
            end
            @(negedge clk);
        end
        din_valid = 1'b0;
        ct_ready = 1'b0;

        check_eq("fin_cnt", 128'(fin), 128'd1);
        check_eq("ct_cnt", 128'(ci), 128'(np));
        check_eq("aes_cnt", 128'(aes_log.size()), 128'(exp_aes.size()));
        for (int i = 0; i < aes_log.size() && i < exp_aes.size(); i++) begin
            check_eq($sformatf("aes_in%0d", i), aes_log[i], exp_aes[i]);
        end
        check_eq("mul_cnt", 128'(mul_log.size()), 128'(na + np + 1));
        if (mul_log.size() > 0) check_eq("len_mul_a", mul_log[$], last_a);
        check_eq("mul_b_h", mul_b, h);
        check_eq("busy_end", 128'(busy), 128'd0);
        if (na + np == 0) check_eq("din_rdy_never", 128'(saw_rdy), 128'd0);
        o_tag = tag;
        o_h = mul_b;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        iv = '0;
        aad_blocks = '0;
        pt_blocks = '0;
        din = '0;
        din_valid = 1'b0;
        ct_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk);

        // Known vector: empty AAD and text.
        run_gcm(96'h0, 0, 0, 1'b1, 0, r_tag, r_ct0, r_h);
        check_eq("tc1_h", r_h, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        check_eq("tc1_tag", r_tag, 128'h58e2fccefa7e3061367f1d57a4e7455a);

        // Known vector: one zero plaintext block.
        run_gcm(96'h0, 0, 1, 1'b1, 0, r_tag, r_ct0, r_h);
        check_eq("tc2_ct", r_ct0, 128'h0388dace60b6a392f328c2b971b2fe78);
        check_eq("tc2_tag", r_tag, 128'hab6e47d42cec13bdf53a67b21257bddf);

        run_gcm(96'hcafebabefacedbaddecaf888, 2, 3, 1'b0, 0, r_tag, r_ct0, r_h);
        run_gcm({$urandom, $urandom, $urandom}, 1, 2, 1'b0, 1, r_tag, r_ct0, r_h);

        // Abort in CT_MUL, then the empty vector again.
        run_gcm({$urandom, $urandom, $urandom}, 1, 2, 1'b0, 2, r_tag, r_ct0, r_h);
        run_gcm(96'h0, 0, 0, 1'b1, 0, r_tag, r_ct0, r_h);
        check_eq("abort_rerun_tag", r_tag, 128'h58e2fccefa7e3061367f1d57a4e7455a);

        run_gcm({$urandom, $urandom, $urandom}, 2, 1, 1'b0, 3, r_tag, r_ct0, r_h);

        for (int r = 0; r < 6; r++) begin
            r_na = $urandom_range(0, 3);
            r_np = $urandom_range(0, 3);
            run_gcm({$urandom, $urandom, $urandom}, r_na, r_np, 1'b0, 0, r_tag, r_ct0, r_h);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
